// File: rtl/fft_twiddle_agu.sv
// Twiddle address generator / fetch sequencer for one radix-2 FFT stage.
// Issues one ROM read per butterfly and streams {re, im, last} through a 2-entry FIFO.
module fft_twiddle_agu #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int STAGE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [STAGE_W-1:0] i_stage,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_rom_rd_en,
  output logic [ADDR_W-1:0]  o_rom_rd_addr,
  input  logic [DATA_W-1:0]  i_rom_re_data,
  input  logic [DATA_W-1:0]  i_rom_im_data,
  output logic               o_tw_valid,
  input  logic               i_tw_ready,
  output logic [DATA_W-1:0]  o_tw_re,
  output logic [DATA_W-1:0]  o_tw_im,
  output logic               o_tw_last
);

  localparam int ENTRY_W = 2 * DATA_W + 1;
  localparam logic [STAGE_W-1:0] MAX_STAGE = STAGE_W'(ADDR_W);
  localparam logic [ADDR_W-1:0]  LAST_J    = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [STAGE_W-1:0]  stage_reg;
  logic [ADDR_W-1:0]   j_reg;
  logic                inflight_reg, inflight_last_reg;
  logic [1:0]          count_reg;
  logic                wr_ptr_reg, rd_ptr_reg;
  logic                done_reg, done_next;
  logic [ENTRY_W-1:0]  fifo_mem [2];

  logic                pop, push, rd_en;
  logic [2:0]          credit;
  logic [ADDR_W-1:0]   addr_mask;
  logic [STAGE_W-1:0]  stage_clamped;

  assign stage_clamped = (i_stage > MAX_STAGE) ? MAX_STAGE : i_stage;
  assign addr_mask     = ~({ADDR_W{1'b1}} << stage_reg);
  assign o_rom_rd_addr = (j_reg & addr_mask) << (MAX_STAGE - stage_reg);

  assign push   = inflight_reg;
  assign pop    = (count_reg != 2'd0) && i_tw_ready;
  // Slots already committed (buffered + in flight), less the one leaving this cycle.
  assign credit = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign rd_en  = (state_reg == RUN) && (credit < 3'd2);

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE:  if (i_start) state_next = RUN;
      RUN:   if (rd_en && (j_reg == LAST_J)) state_next = DRAIN;
      DRAIN: begin
        if (!inflight_reg && ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg         <= IDLE;
      done_reg          <= 1'b0;
      stage_reg         <= '0;
      j_reg             <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      count_reg         <= 2'd0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      fifo_mem[0]       <= '0;
      fifo_mem[1]       <= '0;
    end else begin
      state_reg         <= state_next;
      done_reg          <= done_next;
      inflight_reg      <= rd_en;
      inflight_last_reg <= rd_en && (j_reg == LAST_J);
      if ((state_reg == IDLE) && i_start) begin
        stage_reg <= stage_clamped;
        j_reg     <= '0;
      end else if (rd_en) begin
        j_reg <= j_reg + 1'b1;
      end
      if (push) begin
        fifo_mem[wr_ptr_reg] <= {i_rom_re_data, i_rom_im_data, inflight_last_reg};
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign o_rom_rd_en = rd_en;
  assign o_busy      = (state_reg != IDLE);
  assign o_done      = done_reg;
  assign o_tw_valid  = (count_reg != 2'd0);
  assign {o_tw_re, o_tw_im, o_tw_last} = fifo_mem[rd_ptr_reg];

endmodule

// File: tb/tb_fft_twiddle_agu.sv
// Randomized bench for fft_twiddle_agu: ROM model, reference address/beat sequence, stall checks.
module tb_fft_twiddle_agu;

  logic        clk = 1'b0;
  logic        rst, start, tw_ready;
  logic [3:0]  stage;
  logic        busy, done, rd_en, tw_valid, tw_last;
  logic [8:0]  rd_addr;
  logic [15:0] rom_re, rom_im, tw_re, tw_im;

  logic [15:0] rom_re_tbl [512];
  logic [15:0] rom_im_tbl [512];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fft_twiddle_agu dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stage(stage),
    .o_busy(busy), .o_done(done), .o_rom_rd_en(rd_en), .o_rom_rd_addr(rd_addr),
    .i_rom_re_data(rom_re), .i_rom_im_data(rom_im),
    .o_tw_valid(tw_valid), .i_tw_ready(tw_ready),
    .o_tw_re(tw_re), .o_tw_im(tw_im), .o_tw_last(tw_last)
  );

  // 1-cycle latency ROMs; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    rom_re <= rd_en ? rom_re_tbl[rd_addr] : 16'($urandom);
    rom_im <= rd_en ? rom_im_tbl[rd_addr] : 16'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic int exp_addr(input int s, input int j);
    return (j % (1 << s)) * (512 >> s);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_valid"}, tw_valid, 0);
    check_eq({tag, "_re"}, tw_re, 0);
    check_eq({tag, "_im"}, tw_im, 0);
    check_eq({tag, "_last"}, tw_last, 0);
  endtask

  // mode 0: ready held high, cycle-exact checks; mode 1: stall 5..14 then random ready.
  task automatic run_stage(input int stg, input int mode, input int busy_cyc,
                           input int rst_cyc, input bit skip_wait);
    int s_eff, iss, pops, c, a;
    bit finished, prev_stall;
    logic [32:0] prev_beat;
    s_eff = (stg > 9) ? 9 : stg;
    iss = 0; pops = 0; finished = 0; prev_stall = 0; prev_beat = '0;
    if (!skip_wait) @(negedge clk);
    start = 1'b1; stage = 4'(stg); tw_ready = 1'b1;
    c = 1;
    while (!finished && c < 4000) begin
      @(negedge clk);
      start = (c == busy_cyc);
      stage = (c == busy_cyc) ? 4'd0 : 4'($urandom);
      if (c == rst_cyc) rst = 1'b1;
      if (mode == 0 || c < 5) tw_ready = 1'b1;
      else if (c <= 14) tw_ready = 1'b0;
      else tw_ready = 1'($urandom_range(0, 1));
      if (c == rst_cyc + 1) begin
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        $display("reset mid-run at cycle %0d: %0d reads, %0d beats", c - 1, iss, pops);
        return;
      end
      #1;
      if (c == 1) begin
        check_eq("c1_busy", busy, 1);
        check_eq("c1_rd_en", rd_en, 1);
      end
      if (prev_stall) begin
        check_eq("stall_valid", tw_valid, 1);
        check_eq("stall_stable", {tw_re, tw_im, tw_last}, prev_beat);
      end
      if (rd_en) begin
        if (iss >= 512) check_eq("extra_rd", iss, 511);
        else begin
          check_eq("rd_addr", rd_addr, exp_addr(s_eff, iss));
          if (mode == 0) check_eq("rd_cycle", c, iss + 1);
        end
        iss++;
      end
      if (tw_valid && tw_ready) begin
        if (pops >= 512) check_eq("extra_beat", pops, 511);
        else begin
          a = exp_addr(s_eff, pops);
          check_eq("beat_re", tw_re, rom_re_tbl[a]);
          check_eq("beat_im", tw_im, rom_im_tbl[a]);
          check_eq("beat_last", tw_last, (pops == 511));
          if (mode == 0) check_eq("beat_cycle", c, pops + 3);
        end
        pops++;
      end
      if (iss - pops > 2) check_eq("outstanding", iss - pops, 2);
      prev_stall = tw_valid && !tw_ready;
      prev_beat  = {tw_re, tw_im, tw_last};
      if (done) begin
        check_eq("done_beats", pops, 512);
        check_eq("done_reads", iss, 512);
        check_eq("done_busy", busy, 0);
        if (mode == 0) check_eq("done_cycle", c, 515);
        finished = 1;
      end else begin
        c++;
      end
    end
    if (!finished) check_eq("timeout", 0, 1);
    $display("run stage=%0d mode=%0d: %0d reads, %0d beats, done at cycle %0d", stg, mode, iss, pops, c);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      rom_re_tbl[i] = 16'($urandom);
      rom_im_tbl[i] = 16'($urandom);
    end
    rom_re_tbl[0] = 16'h7FFF;
    rom_im_tbl[0] = 16'h0000;
    rst = 1'b1; start = 1'b0; stage = 4'd0; tw_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    $display("reset state checked");
    @(negedge clk);
    rst = 1'b0;

    run_stage(9, 0, -1, -1, 0);
    run_stage(0, 0, -1, -1, 1);
    check_eq("s0_last_re", tw_re, 16'h7FFF);
    run_stage(3, 0, -1, -1, 0);
    run_stage(12, 0, -1, -1, 0);
    run_stage(9, 1, -1, -1, 0);
    run_stage(9, 0, 100, -1, 0);
    run_stage(9, 1, -1, 200, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("post_rst_done", done, 0);
      check_eq("post_rst_busy", busy, 0);
    end
    run_stage(9, 0, -1, -1, 0);
    for (int k = 0; k < 2; k++) run_stage(int'($urandom_range(0, 15)), 1, -1, -1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
